// File: rtl/xbar_sync_pkg.sv
// Shared constants and types for the xbar word-synchronisation stage.
// Holds the K28.5 comma encodings, the sync FSM state type and the counter width default.
package xbar_sync_pkg;

    localparam logic [9:0] K28_5_N = 10'h17C;
    localparam logic [9:0] K28_5_P = 10'h283;

    localparam int CNT_W_DEFAULT = 16;

    // ERR covers ERR1..ERR_LVLS; the level lives in a separate counter.
    typedef enum logic [1:0] {
        ST_LOS,
        ST_ACQ,
        ST_SYNC,
        ST_ERR
    } sync_state_e;

    function automatic logic is_k28_5(input logic [9:0] sym);
        return (sym == K28_5_N) || (sym == K28_5_P);
    endfunction

endpackage

// File: rtl/xbar_10b_check.sv
// Combinational 8b/10b code-word legality check (no running-disparity tracking).
// Ports: sym = 10b symbol, bit 0 = 'a' (first transmitted); ok = symbol is a legal code word.
module xbar_10b_check
    import xbar_sync_pkg::*;
(
    input  logic [9:0] sym,
    output logic       ok
);

    // Sub-blocks re-ordered so they read abcdei / fghj MSB first.
    logic [5:0] six;
    logic [3:0] four;
    logic       six_n;
    logic       six_p;
    logic       unbal;
    logic       ei_hi;
    logic       ei_lo;
    logic       four_n;
    logic       four_p;
    logic       d_ok;
    logic       k_ok;

    assign six  = {sym[0], sym[1], sym[2], sym[3], sym[4], sym[5]};
    assign four = {sym[6], sym[7], sym[8], sym[9]};

    // 6b sub-block legal when the running disparity is negative.
    assign six_n = six inside {
        6'b100111, 6'b011101, 6'b101101, 6'b110001,
        6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100,
        6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010,
        6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110,
        6'b001110, 6'b101110, 6'b011110, 6'b101011
    };

    // 6b sub-block legal when the running disparity is positive.
    assign six_p = six inside {
        6'b011000, 6'b100010, 6'b010010, 6'b110001,
        6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100,
        6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010,
        6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001,
        6'b001110, 6'b010001, 6'b100001, 6'b010100
    };

    assign unbal = ($countones(six) != 3);
    assign ei_hi = six[1] & six[0];
    assign ei_lo = ~six[1] & ~six[0];

    // D.x.A7 replaces D.x.P7 where P7 would extend an e/i run to five.
    assign four_n =
        (four inside {4'b1011, 4'b1001, 4'b0101, 4'b1100,
                      4'b1101, 4'b1010, 4'b0110}) ||
        (four == 4'b1110 && !ei_hi) ||
        (four == 4'b0111 && ei_hi);

    assign four_p =
        (four inside {4'b0100, 4'b1001, 4'b0101, 4'b0011,
                      4'b0010, 4'b1010, 4'b0110}) ||
        (four == 4'b0001 && !ei_lo) ||
        (four == 4'b1000 && ei_lo);

    // An unbalanced 6b block flips the disparity seen by the 4b block.
    assign d_ok = (six_n && (unbal ? four_p : four_n)) ||
                  (six_p && (unbal ? four_n : four_p));

    assign k_ok = {six, four} inside {
        10'b001111_0100, 10'b001111_1001, 10'b001111_0101,
        10'b001111_0011, 10'b001111_0010, 10'b001111_1010,
        10'b001111_0110, 10'b001111_1000, 10'b111010_1000,
        10'b110110_1000, 10'b101110_1000, 10'b011110_1000,
        10'b110000_1011, 10'b110000_0110, 10'b110000_1010,
        10'b110000_1100, 10'b110000_1101, 10'b110000_0101,
        10'b110000_1001, 10'b110000_0111, 10'b000101_0111,
        10'b001001_0111, 10'b010001_0111, 10'b100001_0111
    };

    assign ok = d_ok || k_ok;

endmodule

// File: rtl/xbar_word_sync.sv
// Word-sync stage after the comma aligner: classifies 40b words, runs loss-of-sync FSM.
// Ports: rx_clk, rx_rst_n (sync, active low), rx_align_data, stat_clr -> rx_sync_data,
//        rx_sync, rx_os_det, rx_word_err, rx_los_cnt, rx_cv_cnt (saturating statistics).
module xbar_word_sync
    import xbar_sync_pkg::*;
#(
    parameter int ACQ_OS_CNT  = 3,
    parameter int ERR_LVLS    = 3,
    parameter int RECOVER_CNT = 2,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             rx_clk,
    input  logic             rx_rst_n,
    input  logic [39:0]      rx_align_data,
    input  logic             stat_clr,
    output logic [39:0]      rx_sync_data,
    output logic             rx_sync,
    output logic             rx_os_det,
    output logic             rx_word_err,
    output logic [CNT_W-1:0] rx_los_cnt,
    output logic [CNT_W-1:0] rx_cv_cnt
);

    localparam int OS_W   = $clog2(ACQ_OS_CNT + 1);
    localparam int GOOD_W = $clog2(RECOVER_CNT + 1);
    localparam int LVL_W  = $clog2(ERR_LVLS + 1);

    localparam logic [OS_W-1:0]   OS_LAST   = OS_W'(ACQ_OS_CNT - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(RECOVER_CNT - 1);
    localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(ERR_LVLS);
    localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);

    logic [3:0] sym_ok;
    logic [3:0] lane_comma;
    logic       word_ok;
    logic       word_os;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        xbar_10b_check u_chk (
            .sym (rx_align_data[10*k +: 10]),
            .ok  (sym_ok[k])
        );
        assign lane_comma[k] = is_k28_5(rx_align_data[10*k +: 10]);
    end

    // A comma outside lane 0 means the aligner has slipped.
    assign word_ok = (&sym_ok) && !(|lane_comma[3:1]);
    assign word_os = word_ok && lane_comma[0];

    // Stage 1
    logic        s1_vld;
    logic [39:0] s1_data;
    logic        s1_ok;
    logic        s1_os;

    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
            s1_ok   <= 1'b0;
            s1_os   <= 1'b0;
        end else begin
            s1_vld  <= 1'b1;
            s1_data <= rx_align_data;
            s1_ok   <= word_ok;
            s1_os   <= word_os;
        end
    end

    // Stage 2: FSM
    sync_state_e       state_q, state_d;
    logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic              los_inc;
    logic              cv_inc;

    always_comb begin
        state_d  = state_q;
        os_cnt_d = os_cnt_q;
        good_d   = good_q;
        lvl_d    = lvl_q;
        los_inc  = 1'b0;
        if (s1_vld) begin
            unique case (state_q)
                ST_LOS, ST_ACQ: begin
                    if (!s1_ok) begin
                        state_d  = ST_LOS;
                        os_cnt_d = '0;
                    end else if (s1_os) begin
                        if (os_cnt_q == OS_LAST) begin
                            state_d  = ST_SYNC;
                            os_cnt_d = '0;
                        end else begin
                            state_d  = ST_ACQ;
                            os_cnt_d = os_cnt_q + 1'b1;
                        end
                    end
                end
                ST_SYNC: begin
                    if (!s1_ok) begin
                        state_d = ST_ERR;
                        lvl_d   = LVL_ONE;
                        good_d  = '0;
                    end
                end
                ST_ERR: begin
                    if (!s1_ok) begin
                        good_d = '0;
                        if (lvl_q == LVL_MAX) begin
                            state_d = ST_LOS;
                            lvl_d   = '0;
                            los_inc = 1'b1;
                        end else begin
                            lvl_d = lvl_q + 1'b1;
                        end
                    end else if (good_q == GOOD_LAST) begin
                        good_d = '0;
                        if (lvl_q == LVL_ONE) begin
                            state_d = ST_SYNC;
                            lvl_d   = '0;
                        end else begin
                            lvl_d = lvl_q - 1'b1;
                        end
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_LOS;
                    os_cnt_d = '0;
                    good_d   = '0;
                    lvl_d    = '0;
                end
            endcase
        end
    end

    assign cv_inc = s1_vld && !s1_ok;

    logic [CNT_W-1:0] los_cnt_q;
    logic [CNT_W-1:0] cv_cnt_q;

    always_ff @(posedge rx_clk) begin
        if (!rx_rst_n) begin
            state_q      <= ST_LOS;
            os_cnt_q     <= '0;
            good_q       <= '0;
            lvl_q        <= '0;
            rx_sync_data <= '0;
            rx_os_det    <= 1'b0;
            rx_word_err  <= 1'b0;
            los_cnt_q    <= '0;
            cv_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            os_cnt_q     <= os_cnt_d;
            good_q       <= good_d;
            lvl_q        <= lvl_d;
            rx_sync_data <= s1_data;
            rx_os_det    <= s1_vld && s1_os;
            rx_word_err  <= cv_inc;
            // Clear wins over a same-cycle increment.
            if (stat_clr) begin
                los_cnt_q <= '0;
            end else if (los_inc && (los_cnt_q != '1)) begin
                los_cnt_q <= los_cnt_q + 1'b1;
            end
            if (stat_clr) begin
                cv_cnt_q <= '0;
            end else if (cv_inc && (cv_cnt_q != '1)) begin
                cv_cnt_q <= cv_cnt_q + 1'b1;
            end
        end
    end

    assign rx_sync    = (state_q == ST_SYNC) || (state_q == ST_ERR);
    assign rx_los_cnt = los_cnt_q;
    assign rx_cv_cnt  = cv_cnt_q;

endmodule

// File: tb/tb_xbar_word_sync.sv
// Self-checking bench for xbar_word_sync: directed scenarios then random words,
// checked every cycle against an encoder-built code table and a rule-level sync model.
module tb_xbar_word_sync;

    localparam int ACQ     = 3;
    localparam int LVLS    = 3;
    localparam int RECOVER = 2;
    localparam int MAXC    = 65535;

    localparam logic [39:0] IDLE = {10'h155, 10'h155, 10'h155, 10'h17C};
    localparam logic [39:0] DATA = {10'h155, 10'h155, 10'h155, 10'h155};
    localparam logic [39:0] BAD  = {10'h155, 10'h000, 10'h155, 10'h155};
    localparam logic [39:0] KL1  = {10'h155, 10'h155, 10'h17C, 10'h155};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stat_clr;
    logic [39:0] din;
    logic [39:0] rx_sync_data;
    logic        rx_sync;
    logic        rx_os_det;
    logic        rx_word_err;
    logic [15:0] rx_los_cnt;
    logic [15:0] rx_cv_cnt;

    always #5 clk = ~clk;

    xbar_word_sync dut (
        .rx_clk        (clk),
        .rx_rst_n      (rst_n),
        .rx_align_data (din),
        .stat_clr      (stat_clr),
        .rx_sync_data  (rx_sync_data),
        .rx_sync       (rx_sync),
        .rx_os_det     (rx_os_det),
        .rx_word_err   (rx_word_err),
        .rx_los_cnt    (rx_los_cnt),
        .rx_cv_cnt     (rx_cv_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit         legal [1024];
    logic [5:0] t6 [32];
    logic [3:0] t4 [8];
    logic [9:0] tk [12];

    // reference model state
    logic [39:0] m1_data;
    bit          m1_vld, m1_ok, m1_os;
    logic [39:0] m_data;
    bit          m_os, m_err, m_synced;
    int          m_hunt, m_lvl, m_good, m_los, m_cv;

    task automatic mark(input logic [9:0] code);
        logic [9:0] s;
        for (int i = 0; i < 10; i++) s[i] = code[9-i];
        legal[s] = 1'b1;
    endtask

    // Enumerate every code word a transmitter can emit, both disparities.
    task automatic build_legal();
        logic [5:0] c6;
        logic [3:0] c4;
        int         rd4;
        bit         unb6, a7;
        for (int i = 0; i < 1024; i++) legal[i] = 1'b0;
        for (int x = 0; x < 32; x++)
            for (int y = 0; y < 8; y++)
                for (int rd = 0; rd < 2; rd++) begin
                    c6   = t6[x];
                    unb6 = ($countones(c6) != 3);
                    if (rd == 1 && (unb6 || x == 7)) c6 = ~c6;
                    rd4 = unb6 ? 1 - rd : rd;
                    a7  = (y == 7) &&
                          ((rd4 == 0 && (x == 17 || x == 18 || x == 20)) ||
                           (rd4 == 1 && (x == 11 || x == 13 || x == 14)));
                    c4 = a7 ? 4'b0111 : t4[y];
                    if (rd4 == 1 && ($countones(c4) != 2 || y == 3)) c4 = ~c4;
                    mark({c6, c4});
                end
        for (int i = 0; i < 12; i++) begin
            mark(tk[i]);
            mark(~tk[i]);
        end
    endtask

    function automatic bit is_comma(input logic [9:0] s);
        return (s == 10'h17C) || (s == 10'h283);
    endfunction

    task automatic classify(input logic [39:0] w, output bit ok, output bit os);
        logic [9:0] s;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s = w[10*k +: 10];
            if (!legal[s]) ok = 1'b0;
            if (k > 0 && is_comma(s)) ok = 1'b0;
        end
        os = ok && is_comma(w[9:0]);
    endtask

    task automatic model_reset();
        m1_data = '0; m1_vld = 0; m1_ok = 0; m1_os = 0;
        m_data = '0; m_os = 0; m_err = 0; m_synced = 0;
        m_hunt = 0; m_lvl = 0; m_good = 0; m_los = 0; m_cv = 0;
    endtask

    task automatic model_fsm(input bit ok, input bit os, output bit los_ev);
        los_ev = 1'b0;
        if (!m_synced) begin
            if (!ok) m_hunt = 0;
            else if (os) begin
                m_hunt++;
                if (m_hunt == ACQ) begin
                    m_synced = 1; m_hunt = 0; m_lvl = 0; m_good = 0;
                end
            end
        end else if (!ok) begin
            m_good = 0;
            if (m_lvl == LVLS) begin
                m_synced = 0; m_hunt = 0; m_lvl = 0; los_ev = 1'b1;
            end else m_lvl++;
        end else if (m_lvl > 0) begin
            m_good++;
            if (m_good == RECOVER) begin
                m_good = 0; m_lvl--;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("data", rx_sync_data, m_data);
        chk("sync", 40'(rx_sync), 40'(m_synced));
        chk("os_det", 40'(rx_os_det), 40'(m_os));
        chk("word_err", 40'(rx_word_err), 40'(m_err));
        chk("los_cnt", 40'(rx_los_cnt), 40'(m_los));
        chk("cv_cnt", 40'(rx_cv_cnt), 40'(m_cv));
    endtask

    task automatic step(input logic [39:0] w, input bit clr, input bit rst, input bit do_chk);
        bit ok, os, ev;
        rst_n = !rst;
        stat_clr = clr;
        din = w;
        if (rst) model_reset();
        else begin
            m_data = m1_data;
            m_os   = m1_vld && m1_os;
            m_err  = m1_vld && !m1_ok;
            ev = 1'b0;
            if (m1_vld) model_fsm(m1_ok, m1_os, ev);
            if (clr) begin
                m_cv = 0; m_los = 0;
            end else begin
                if (m_err && m_cv < MAXC) m_cv++;
                if (ev && m_los < MAXC) m_los++;
            end
            classify(w, ok, os);
            m1_data = w; m1_vld = 1; m1_ok = ok; m1_os = os;
        end
        @(posedge clk);
        #1;
        if (do_chk) check_all();
    endtask

    task automatic go(input logic [39:0] w);
        step(w, 1'b0, 1'b0, 1'b1);
    endtask

    function automatic logic [9:0] rand_sym();
        logic [9:0] s;
        for (int i = 0; i < 64; i++) begin
            s = 10'($urandom);
            if (legal[s] && !is_comma(s)) return s;
        end
        return 10'h155;
    endfunction

    function automatic logic [39:0] rand_word();
        logic [39:0] w;
        int          r, ln;
        r = int'($urandom_range(0, 99));
        w = {rand_sym(), rand_sym(), rand_sym(), rand_sym()};
        if (r < 45) begin
            w[9:0] = ($urandom_range(0, 1) == 0) ? 10'h17C : 10'h283;
        end else if (r < 70) begin
        end else if (r < 82) begin
            ln = int'($urandom_range(0, 3));
            w[10*ln +: 10] = 10'($urandom);
        end else if (r < 90) begin
            ln = int'($urandom_range(1, 3));
            w[10*ln +: 10] = 10'h17C;
        end else begin
            w = {8'($urandom), 32'($urandom)};
        end
        return w;
    endfunction

    initial begin
        t6 = '{6'b100111, 6'b011101, 6'b101101, 6'b110001,
               6'b110101, 6'b101001, 6'b011001, 6'b111000,
               6'b111001, 6'b100101, 6'b010101, 6'b110100,
               6'b001101, 6'b101100, 6'b011100, 6'b010111,
               6'b011011, 6'b100011, 6'b010011, 6'b110010,
               6'b001011, 6'b101010, 6'b011010, 6'b111010,
               6'b110011, 6'b100110, 6'b010110, 6'b110110,
               6'b001110, 6'b101110, 6'b011110, 6'b101011};
        t4 = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
               4'b1101, 4'b1010, 4'b0110, 4'b1110};
        tk = '{10'b001111_0100, 10'b001111_1001, 10'b001111_0101,
               10'b001111_0011, 10'b001111_0010, 10'b001111_1010,
               10'b001111_0110, 10'b001111_1000, 10'b111010_1000,
               10'b110110_1000, 10'b101110_1000, 10'b011110_1000};
        build_legal();
        model_reset();
        rst_n = 1'b0;
        stat_clr = 1'b0;
        din = '0;

        // 1: reset, then idle acquisition
        step(IDLE, 1'b0, 1'b1, 1'b1);
        step(IDLE, 1'b0, 1'b1, 1'b1);
        chk("reset_sync", 40'(rx_sync), 40'd0);
        go(IDLE); go(IDLE); go(IDLE);
        chk("acq_before_3rd", 40'(rx_sync), 40'd0);
        go(IDLE);
        chk("acq_at_3rd", 40'(rx_sync), 40'd1);
        repeat (4) go(IDLE);
        chk("t1_cv", 40'(rx_cv_cnt), 40'd0);

        // 2: single error then recovery
        go(BAD); go(DATA);
        chk("t2_err_flag", 40'(rx_word_err), 40'd1);
        chk("t2_sync_err1", 40'(rx_sync), 40'd1);
        repeat (3) go(DATA);
        chk("t2_cv", 40'(rx_cv_cnt), 40'd1);

        // 3: four spaced errors -> LOS
        step(IDLE, 1'b1, 1'b0, 1'b1);
        repeat (3) begin
            go(BAD); go(DATA);
        end
        go(BAD); go(DATA); go(DATA);
        chk("t3_sync", 40'(rx_sync), 40'd0);
        chk("t3_los", 40'(rx_los_cnt), 40'd1);
        chk("t3_cv", 40'(rx_cv_cnt), 40'd4);

        // 4: interrupted acquisition
        go(IDLE); go(IDLE); go(BAD); go(IDLE);
        chk("t4_pair", 40'(rx_sync), 40'd0);
        go(IDLE); go(IDLE);
        chk("t4_two", 40'(rx_sync), 40'd0);
        go(DATA);
        chk("t4_three", 40'(rx_sync), 40'd1);
        go(DATA);

        // 5: misaligned comma resets the acquisition count
        repeat (4) go(BAD);
        go(DATA); go(DATA);
        chk("t5_los", 40'(rx_los_cnt), 40'd2);
        go(IDLE); go(IDLE); go(KL1); go(IDLE);
        chk("t5_kerr", 40'(rx_word_err), 40'd1);
        chk("t5_kos", 40'(rx_os_det), 40'd0);
        go(IDLE); go(DATA); go(DATA);
        chk("t5_nosync", 40'(rx_sync), 40'd0);
        go(IDLE); go(DATA);
        chk("t5_sync", 40'(rx_sync), 40'd1);

        // 6: saturation and clear priority
        go(IDLE); go(IDLE);
        force dut.cv_cnt_q = 16'hFFFE;
        step(IDLE, 1'b0, 1'b0, 1'b0);
        release dut.cv_cnt_q;
        m_cv = 16'hFFFE;
        go(BAD); go(BAD); go(BAD); go(DATA); go(DATA);
        chk("t6_sat", 40'(rx_cv_cnt), 40'hFFFF);
        go(BAD);
        step(BAD, 1'b1, 1'b0, 1'b1);
        chk("t6_clr", 40'(rx_cv_cnt), 40'd0);
        go(DATA); go(DATA);

        // random traffic with occasional clear and reset
        for (int i = 0; i < 800; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            step(rand_word(), (r < 3), (r == 99), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
